// File: rtl/regfile_seq_ctrl_pkg.sv
// Shared definitions for the register-file sequencing controller:
// default widths, the controller state encoding and the ALU opcode map.
package regfile_seq_ctrl_pkg;

  // Default widths: 64 x 32 register file and a 5-bit ALU opcode.
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int OP_W   = 5;

  // Controller states. busy is asserted in SEED0, SEED1 and RUN.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED0 = 3'd1,
    ST_SEED1 = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Opcodes understood by the shared ALU. The controller only passes the
  // latched opcode through; the ALU decides what it means.
  localparam logic [OP_W-1:0] OP_ADD = 5'h01;
  localparam logic [OP_W-1:0] OP_SUB = 5'h02;
  localparam logic [OP_W-1:0] OP_AND = 5'h03;
  localparam logic [OP_W-1:0] OP_OR  = 5'h04;
  localparam logic [OP_W-1:0] OP_XOR = 5'h05;

endpackage : regfile_seq_ctrl_pkg

// File: rtl/regfile_seq_ctrl_if.sv
// Bundle of the requester handshake, ALU operand/result and register-file
// write-port signals seen by the sequencing controller.
// The master side is the surrounding system (requester, ALU, register file);
// the slave side is the controller itself.
interface regfile_seq_ctrl_if #(
  parameter int DATA_W = regfile_seq_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_seq_ctrl_pkg::ADDR_W,
  parameter int OP_W   = regfile_seq_ctrl_pkg::OP_W
);

  // Requester side
  logic              start;
  logic [DATA_W-1:0] seed0;
  logic [DATA_W-1:0] seed1;
  logic [OP_W-1:0]   op;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              err;

  // ALU side
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_y;

  // Register-file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output start, seed0, seed1, op, len, alu_y,
    input  busy, done, err, alu_a, alu_b, alu_op, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  start, seed0, seed1, op, len, alu_y,
    output busy, done, err, alu_a, alu_b, alu_op, rf_we, rf_waddr, rf_wdata
  );

endinterface : regfile_seq_ctrl_if

// File: rtl/regfile_seq_ctrl.sv
// Sequencing controller that fills the register file with a two-term
// recurrence: address 0 <- seed0, address 1 <- seed1, then
// y[k] = alu(y[k-2], y[k-1], op) for k = 2 .. len-1, one write per cycle.
// The ALU and register file live outside; this block drives their operands
// and write port and reports busy/done/err to the requester.
module regfile_seq_ctrl
  import regfile_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = regfile_seq_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_seq_ctrl_pkg::ADDR_W,
  parameter int OP_W   = regfile_seq_ctrl_pkg::OP_W
) (
  input  logic               clk,
  input  logic               rst,
  regfile_seq_ctrl_if.slave  bus
);

  // len carries one extra bit so that a full-depth run (2**ADDR_W) fits.
  localparam int                LEN_W   = ADDR_W + 1;
  localparam logic [LEN_W-1:0]  LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(1) << ADDR_W;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d;      // older term, y[k-2]
  logic [DATA_W-1:0]  b_q, b_d;      // newer term, y[k-1]
  logic [ADDR_W-1:0]  k_q, k_d;      // address of the write in progress
  logic [OP_W-1:0]    op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               err_q, err_d;

  logic               len_legal;
  logic               last_step;

  // A request is legal only for 2..2**ADDR_W entries.
  assign len_legal = (bus.len >= LEN_MIN) && (bus.len <= LEN_MAX);

  // The write at address len-1 is the final one; k stops there so it
  // never wraps, even for a full-depth run ending at the top address.
  assign last_step = ({1'b0, k_q} == (len_q - LEN_W'(1)));

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      op_q    <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      op_q    <= op_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start acceptance, seeding and the recurrence shift.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    op_d    = op_q;
    len_d   = len_q;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // start is only looked at here; requests while busy or in DONE
        // are dropped rather than queued.
        if (bus.start) begin
          if (len_legal) begin
            a_d     = bus.seed0;
            b_d     = bus.seed1;
            op_d    = bus.op;
            len_d   = bus.len;
            k_d     = '0;
            state_d = ST_SEED0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end

      ST_SEED0: begin
        k_d     = ADDR_W'(1);
        state_d = ST_SEED1;
      end

      ST_SEED1: begin
        k_d     = ADDR_W'(2);
        state_d = (len_q == LEN_MIN) ? ST_DONE : ST_RUN;
      end

      ST_RUN: begin
        // Slide the two-term window: the ALU result written this cycle
        // becomes the newer operand for the next step.
        a_d = b_q;
        b_d = bus.alu_y;
        if (last_step) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: write port and status flags follow the current state.
  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;

    unique case (state_q)
      ST_SEED0: begin
        bus.busy     = 1'b1;
        bus.rf_we    = 1'b1;
        bus.rf_waddr = k_q;
        bus.rf_wdata = a_q;
      end
      ST_SEED1: begin
        bus.busy     = 1'b1;
        bus.rf_we    = 1'b1;
        bus.rf_waddr = k_q;
        bus.rf_wdata = b_q;
      end
      ST_RUN: begin
        // Combinational ALU result goes straight to the write port.
        bus.busy     = 1'b1;
        bus.rf_we    = 1'b1;
        bus.rf_waddr = k_q;
        bus.rf_wdata = bus.alu_y;
      end
      ST_DONE: begin
        bus.done     = 1'b1;
      end
      default: begin
        bus.busy     = 1'b0;
      end
    endcase
  end

  // ALU operands are the operand registers themselves, valid in every state.
  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;
  assign bus.alu_op = op_q;
  assign bus.err    = err_q;

endmodule : regfile_seq_ctrl
